apb_reg_slave: RTL and testbench

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_reg_slave_regfile.sv | 42 ++++
 rtl/apb_reg_slave.sv | 112 +++++++++++
 tb/tb_apb_reg_slave.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and register map for the APB register slave.
// Offsets are word indices taken from PADDR[4:2].
package apb_pkg;

   localparam int ADDR_IDX_W = 3;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS
   } state_t;

   localparam logic [ADDR_IDX_W-1:0] IDX_REG0     = 3'd0;
   localparam logic [ADDR_IDX_W-1:0] IDX_REG1     = 3'd1;
   localparam logic [ADDR_IDX_W-1:0] IDX_REG2     = 3'd2;
   localparam logic [ADDR_IDX_W-1:0] IDX_REG3     = 3'd3;
   localparam logic [ADDR_IDX_W-1:0] IDX_ID       = 3'd4;
   localparam logic [ADDR_IDX_W-1:0] IDX_XFER_CNT = 3'd5;
   localparam logic [ADDR_IDX_W-1:0] IDX_UNMAP0   = 3'd6;

   localparam logic [31:0] ID_VALUE = 32'hA5B0_0001;

   // Writes to read-only words and any touch of the unmapped tail are errors.
   function automatic logic access_err(input logic [ADDR_IDX_W-1:0] idx, input logic write);
      return (idx >= IDX_UNMAP0) || (write && (idx == IDX_ID || idx == IDX_XFER_CNT));
   endfunction

endpackage

// File: rtl/apb_reg_slave_regfile.sv
// Register storage and read decode: REG0..REG3, constant ID and the
// transfer counter. Writes to read-only or unmapped words are dropped here.
module apb_reg_slave_regfile
   import apb_pkg::*;
(
   input  logic                  clk_sys,
   input  logic                  rst_b,
   input  logic                  wr_en,
   input  logic                  inc_en,
   input  logic [ADDR_IDX_W-1:0] wr_idx,
   input  logic [31:0]           wr_data,
   input  logic [ADDR_IDX_W-1:0] rd_idx,
   output logic [31:0]           rd_data
);

   logic [31:0] regs [4];
   logic [31:0] xfer_cnt;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (wr_en && wr_idx <= IDX_REG3) begin
         regs[wr_idx[1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) xfer_cnt <= '0;
      else if (inc_en) xfer_cnt <= xfer_cnt + 32'd1;
   end

   always_comb begin
      rd_data = '0;
      case (rd_idx)
         IDX_REG0, IDX_REG1, IDX_REG2, IDX_REG3: rd_data = regs[rd_idx[1:0]];
         IDX_ID:                                 rd_data = ID_VALUE;
         IDX_XFER_CNT:                           rd_data = xfer_cnt;
         default:                                rd_data = '0;
      endcase
   end

endmodule

// File: rtl/apb_reg_slave.sv
// APB register slave with WAIT_CYCLES access-phase wait states.
// Define APB_REG_SLAVE_SLVERR_EN to report PSLVERR on illegal accesses.
//
// state    | meaning
// S_IDLE   | waiting for a setup phase (PSEL=1, PENABLE=0)
// S_WAIT   | wait-state down-counter running, abort if PSEL drops
// S_ACCESS | PREADY high for one cycle, write/count committed at its end
module apb_reg_slave
   import apb_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic [31:0] PADDR,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR
);

   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  capture;
   logic [ADDR_IDX_W-1:0] addr_q, cur_idx;
   logic                  write_q;
   logic [31:0]           wdata_q, rd_data;
   logic                  commit;
   logic                  unused_addr;

   assign unused_addr = ^{PADDR[31:5], PADDR[1:0]};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            if (PSEL && !PENABLE) begin
               capture   = 1'b1;
               cnt_nxt   = CNT_LOAD;
               state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            end
         end
         S_WAIT: begin
            if (!PSEL) begin
               state_nxt = S_IDLE;
            end else if (PENABLE) begin
               if (cnt == '0) state_nxt = S_ACCESS;
               else           cnt_nxt   = cnt - 1'b1;
            end
         end
         S_ACCESS: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // With zero wait states ACCESS follows setup directly, so decode from the live bus.
   assign cur_idx = capture ? PADDR[4:2] : addr_q;
   assign commit  = (state == S_ACCESS);

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state   <= S_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         PREADY  <= 1'b0;
         PRDATA  <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         PREADY <= (state_nxt == S_ACCESS);
         PRDATA <= (state_nxt == S_ACCESS) ? rd_data : '0;
         if (capture) begin
            addr_q  <= PADDR[4:2];
            write_q <= PWRITE;
            wdata_q <= PWDATA;
         end
      end
   end

`ifdef APB_REG_SLAVE_SLVERR_EN
   logic cur_write;
   assign cur_write = capture ? PWRITE : write_q;

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) PSLVERR <= 1'b0;
      else         PSLVERR <= (state_nxt == S_ACCESS) && access_err(cur_idx, cur_write);
   end
`else
   assign PSLVERR = 1'b0;
`endif

   apb_reg_slave_regfile u_regfile (
      .clk_sys (PCLK),
      .rst_b   (PRESET),
      .wr_en   (commit && write_q),
      .inc_en  (commit),
      .wr_idx  (addr_q),
      .wr_data (wdata_q),
      .rd_idx  (cur_idx),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: three instances with WAIT_CYCLES 1, 0 and 3
// share clock and reset; each scenario task checks its own expectations.
module tb_apb_reg_slave;

   localparam logic EXP_ERR =
`ifdef APB_REG_SLAVE_SLVERR_EN
      1'b1;
`else
      1'b0;
`endif

   logic        pclk = 1'b0;
   logic        preset;
   logic [31:0] paddr  [3];
   logic [31:0] pwdata [3];
   logic [31:0] prdata [3];
   logic        psel   [3];
   logic        penable[3];
   logic        pwrite [3];
   logic        pready [3];
   logic        pslverr[3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 pclk = ~pclk;

   // index 0: WAIT_CYCLES=1, index 1: WAIT_CYCLES=0, index 2: WAIT_CYCLES=3
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WC = (g == 0) ? 1 : (g == 1) ? 0 : 3;
      apb_reg_slave #(.WAIT_CYCLES(WC)) u_dut (
         .PCLK    (pclk),
         .PRESET  (preset),
         .PADDR   (paddr[g]),
         .PSEL    (psel[g]),
         .PENABLE (penable[g]),
         .PWRITE  (pwrite[g]),
         .PWDATA  (pwdata[g]),
         .PRDATA  (prdata[g]),
         .PREADY  (pready[g]),
         .PSLVERR (pslverr[g])
      );
   end

   // rcyc = access-phase cycle in which PREADY was seen, 0 if never (abort or timeout)
   task automatic xfer(input int d, input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input int abort_at, output logic [31:0] rdata, output logic err, output int rcyc);
      rcyc  = 0;
      rdata = 'x;
      err   = 1'bx;
      @(negedge pclk);
      psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = addr; pwrite[d] = wr; pwdata[d] = wdata;
      for (int k = 1; k <= 20; k++) begin
         @(negedge pclk);
         if (k == abort_at) begin
            psel[d] = 1'b0; penable[d] = 1'b0;
            break;
         end
         penable[d] = 1'b1;
         if (pready[d] === 1'b1) begin
            rcyc = k; rdata = prdata[d]; err = pslverr[d];
            break;
         end
      end
   endtask

   task automatic bus_idle(input int d);
      @(negedge pclk);
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask

   task automatic test_reset();
      preset = 1'b0;
      repeat (2) @(negedge pclk);
      for (int d = 0; d < 3; d++) begin
         n_checks++; if (pready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pready[%0d]: got %b want 0", d, pready[d]); end
         n_checks++; if (prdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_prdata[%0d]: got %h want 0", d, prdata[d]); end
         n_checks++; if (pslverr[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr[%0d]: got %b want 0", d, pslverr[d]); end
      end
      preset = 1'b1;
      @(negedge pclk);
   endtask

   task automatic test_wait1();
      logic [31:0] rd; logic er; int rc;
      xfer(0, 32'h00, 1'b1, 32'hDEAD_BEEF, 0, rd, er, rc);
      n_checks++; if (rc != 2) begin n_fail++; $display("FAIL w1_wr_latency: got %0d want 2", rc); end
      n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL w1_wr_err: got %b want 0", er); end
      xfer(0, 32'h00, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rc != 2) begin n_fail++; $display("FAIL w1_rd_latency: got %0d want 2", rc); end
      n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL w1_rd_data: got %h want deadbeef", rd); end
      n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL w1_rd_err: got %b want 0", er); end
      xfer(0, 32'hFFFF_FFE3, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL w1_addr_alias: got %h want deadbeef", rd); end
      bus_idle(0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int rc;
      xfer(1, 32'h04, 1'b1, 32'h1, 0, rd, er, rc);
      n_checks++; if (rc != 1) begin n_fail++; $display("FAIL b2b_wr1_latency: got %0d want 1", rc); end
      xfer(1, 32'h08, 1'b1, 32'h2, 0, rd, er, rc);
      n_checks++; if (rc != 1) begin n_fail++; $display("FAIL b2b_wr2_latency: got %0d want 1", rc); end
      xfer(1, 32'h14, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL b2b_cnt: got %h want 2", rd); end
      xfer(1, 32'h04, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL b2b_rd_reg1: got %h want 1", rd); end
      xfer(1, 32'h08, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL b2b_rd_reg2: got %h want 2", rd); end
      n_checks++; if (rc != 1) begin n_fail++; $display("FAIL b2b_rd_latency: got %0d want 1", rc); end
      bus_idle(1);
   endtask

   task automatic test_discard();
      logic [31:0] rd; logic er; int rc;
      xfer(0, 32'h10, 1'b1, 32'h0, 0, rd, er, rc);
      n_checks++; if (er !== EXP_ERR) begin n_fail++; $display("FAIL id_wr_err: got %b want %b", er, EXP_ERR); end
      xfer(0, 32'h10, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'hA5B0_0001) begin n_fail++; $display("FAIL id_rd: got %h want a5b00001", rd); end
      n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL id_rd_err: got %b want 0", er); end
      xfer(0, 32'h18, 1'b1, 32'hFFFF, 0, rd, er, rc);
      n_checks++; if (er !== EXP_ERR) begin n_fail++; $display("FAIL unmap_wr_err: got %b want %b", er, EXP_ERR); end
      xfer(0, 32'h1C, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmap_rd: got %h want 0", rd); end
      n_checks++; if (er !== EXP_ERR) begin n_fail++; $display("FAIL unmap_rd_err: got %b want %b", er, EXP_ERR); end
      xfer(0, 32'h14, 1'b1, 32'h1234, 0, rd, er, rc);
      n_checks++; if (er !== EXP_ERR) begin n_fail++; $display("FAIL cnt_wr_err: got %b want %b", er, EXP_ERR); end
      xfer(0, 32'h00, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reg0_kept: got %h want deadbeef", rd); end
      xfer(0, 32'h14, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'd9) begin n_fail++; $display("FAIL cnt_all_xfers: got %h want 9", rd); end
      bus_idle(0);
   endtask

   task automatic test_idle_penable();
      logic [31:0] rd; logic er; int rc;
      @(negedge pclk);
      psel[1] = 1'b1; penable[1] = 1'b1; paddr[1] = 32'h04; pwrite[1] = 1'b1; pwdata[1] = 32'h77;
      for (int k = 0; k < 4; k++) begin
         @(negedge pclk);
         n_checks++; if (pready[1] !== 1'b0) begin n_fail++; $display("FAIL idle_penable_ready[%0d]: got %b want 0", k, pready[1]); end
      end
      psel[1] = 1'b0; penable[1] = 1'b0;
      xfer(1, 32'h04, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL idle_penable_nowrite: got %h want 1", rd); end
      bus_idle(1);
   endtask

   task automatic test_abort();
      logic [31:0] rd; logic er; int rc;
      xfer(2, 32'h04, 1'b1, 32'hCAFE, 2, rd, er, rc);
      n_checks++; if (rc != 0) begin n_fail++; $display("FAIL abort_ready_seen: got cycle %0d want none", rc); end
      for (int k = 0; k < 5; k++) begin
         @(negedge pclk);
         n_checks++; if (pready[2] !== 1'b0) begin n_fail++; $display("FAIL abort_ready[%0d]: got %b want 0", k, pready[2]); end
      end
      xfer(2, 32'h04, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_reg1: got %h want 0", rd); end
      n_checks++; if (rc != 4) begin n_fail++; $display("FAIL w3_latency: got %0d want 4", rc); end
      xfer(2, 32'h14, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL abort_cnt: got %h want 1", rd); end
      bus_idle(2);
   endtask

   task automatic test_wrap();
      logic [31:0] rd; logic er; int rc;
      @(negedge pclk);
      force g_dut[1].u_dut.u_regfile.xfer_cnt = 32'hFFFF_FFFF;
      #1;
      release g_dut[1].u_dut.u_regfile.xfer_cnt;
      xfer(1, 32'h14, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_pre: got %h want ffffffff", rd); end
      xfer(1, 32'h14, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wrap_post: got %h want 0", rd); end
      bus_idle(1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int rc;
      @(negedge pclk);
      for (int d = 0; d < 3; d += 2) begin
         psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = 32'h00; pwrite[d] = 1'b0;
      end
      @(negedge pclk);
      penable[0] = 1'b1; penable[2] = 1'b1;
      @(negedge pclk);
      n_checks++; if (prdata[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rstmid_pre_data: got %h want deadbeef", prdata[0]); end
      #2 preset = 1'b0;
      #1;
      n_checks++; if (pready[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready0: got %b want 0", pready[0]); end
      n_checks++; if (prdata[0] !== 32'h0) begin n_fail++; $display("FAIL rstmid_data0: got %h want 0", prdata[0]); end
      n_checks++; if (pready[2] !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready2: got %b want 0", pready[2]); end
      n_checks++; if (prdata[2] !== 32'h0) begin n_fail++; $display("FAIL rstmid_data2: got %h want 0", prdata[2]); end
      for (int d = 0; d < 3; d++) begin psel[d] = 1'b0; penable[d] = 1'b0; end
      @(negedge pclk);
      preset = 1'b1;
      xfer(0, 32'h00, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_reg0: got %h want 0", rd); end
      n_checks++; if (rc != 2) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 2", rc); end
      xfer(0, 32'h14, 1'b0, 32'h0, 0, rd, er, rc);
      n_checks++; if (rd !== 32'd1) begin n_fail++; $display("FAIL rstmid_cnt: got %h want 1", rd); end
      bus_idle(0);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
      end
      test_reset();
      test_wait1();
      test_back_to_back();
      test_discard();
      test_idle_penable();
      test_abort();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
